// File: rtl/seq_mon_pkg.sv
// Shared constants and helpers for the range-sequence monitor.
// Also holds the popcount used to count retired attempts.
package seq_mon_pkg;

  localparam int MAX_DELAY_LIMIT = 31;
  localparam int INC_W = 6;

  // Number of attempts retired in one cycle; at most MAX_DELAY_LIMIT, so fits INC_W bits.
  function automatic logic [INC_W-1:0] popcount(input logic [MAX_DELAY_LIMIT:1] v);
    logic [INC_W-1:0] n;
    n = '0;
    for (int i = 1; i <= MAX_DELAY_LIMIT; i++) begin
      n = n + INC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator used for the match/fail statistics.
// Adds a small increment each cycle and sticks at all-ones instead of wrapping.
module sat_counter
  import seq_mon_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);

  logic [W+INC_W-1:0] sum;

  assign sum = (W+INC_W)'(cnt) + (W+INC_W)'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sum > (W+INC_W)'({W{1'b1}})) begin
      cnt <= {W{1'b1}};
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/seq_delay_range_monitor.sv
// Recogniser for "a ##[MIN_DELAY:MAX_DELAY] b" with overlapping attempts,
// registered match/fail pulses and saturating statistics counters.
module seq_delay_range_monitor
  import seq_mon_pkg::*;
#(
  parameter int MIN_DELAY = 1,
  parameter int MAX_DELAY = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             a,
  input  logic             b,
  output logic             match,
  output logic             fail,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  if (MIN_DELAY < 1 || MAX_DELAY < MIN_DELAY || MAX_DELAY > MAX_DELAY_LIMIT) begin : g_bad_params
    $fatal(1, "seq_delay_range_monitor: illegal MIN_DELAY/MAX_DELAY combination");
  end

  logic [MAX_DELAY:1]       pending;
  logic [MAX_DELAY:1]       hit;
  logic [MAX_DELAY:1]       next_pending;
  logic [MAX_DELAY_LIMIT:1] hit_wide;
  logic                     fail_next;
  logic                     sample;
  logic [INC_W-1:0]         match_inc;
  logic [INC_W-1:0]         fail_inc;

  assign sample    = en & ~clear;
  assign busy      = |pending;
  assign fail_next = pending[MAX_DELAY] & ~hit[MAX_DELAY];

  // Slots younger than MIN_DELAY ignore b; a hit retires the attempt so it stops ageing.
  always_comb begin
    hit          = '0;
    next_pending = '0;
    next_pending[1] = a;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      hit[k] = pending[k] & b & (k >= MIN_DELAY);
    end
    for (int k = 1; k < MAX_DELAY; k++) begin
      next_pending[k+1] = pending[k] & ~hit[k];
    end
  end

  always_comb begin
    hit_wide = '0;
    hit_wide[MAX_DELAY:1] = hit;
  end

  assign match_inc = sample ? popcount(hit_wide) : '0;
  assign fail_inc  = (sample && fail_next) ? INC_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      match   <= 1'b0;
      fail    <= 1'b0;
    end else if (clear) begin
      pending <= '0;
      match   <= 1'b0;
      fail    <= 1'b0;
    end else if (en) begin
      pending <= next_pending;
      match   <= |hit;
      fail    <= fail_next;
    end else begin
      match   <= 1'b0;
      fail    <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (match_inc),
    .cnt   (match_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (fail_inc),
    .cnt   (fail_cnt)
  );

endmodule

// File: tb/tb_seq_delay_range_monitor.sv
// Scoreboard bench for seq_delay_range_monitor: three configurations share one stimulus bus,
// an attempt-age model predicts each cycle and the selected instance is compared.
module tb_seq_delay_range_monitor;

  typedef struct packed {
    logic        match;
    logic        fail;
    logic        busy;
    logic [15:0] mcnt;
    logic [15:0] fcnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;

  logic m0, f0, bz0, m1, f1, bz1, m2, f2, bz2;
  logic [15:0] mc0, fc0, mc1, fc1;
  logic [1:0]  mc2, fc2;

  obs_t expq[$];
  int   ages[$];
  int   checks = 0;
  int   failures = 0;
  int   sel, minD, maxD, cntMax, mCnt, fCnt;

  always #5 clk = ~clk;

  seq_delay_range_monitor dut_def (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b),
    .match(m0), .fail(f0), .busy(bz0), .match_cnt(mc0), .fail_cnt(fc0)
  );

  seq_delay_range_monitor #(.MIN_DELAY(2)) dut_min2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b),
    .match(m1), .fail(f1), .busy(bz1), .match_cnt(mc1), .fail_cnt(fc1)
  );

  seq_delay_range_monitor #(.CNT_W(2)) dut_cnt2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b),
    .match(m2), .fail(f2), .busy(bz2), .match_cnt(mc2), .fail_cnt(fc2)
  );

  function automatic obs_t observe();
    obs_t o;
    case (sel)
      1: begin o.match = m1; o.fail = f1; o.busy = bz1; o.mcnt = mc1; o.fcnt = fc1; end
      2: begin o.match = m2; o.fail = f2; o.busy = bz2; o.mcnt = {14'b0, mc2}; o.fcnt = {14'b0, fc2}; end
      default: begin o.match = m0; o.fail = f0; o.busy = bz0; o.mcnt = mc0; o.fcnt = fc0; end
    endcase
    return o;
  endfunction

  // Reference keeps a list of live attempt ages rather than a slot vector.
  task automatic modelStep(input logic ia, ib, ien, iclr, irst, output obs_t e);
    int nxt[$];
    int hits;
    logic fl;
    hits = 0;
    fl = 1'b0;
    if (!irst || iclr) begin
      ages.delete();
      mCnt = 0;
      fCnt = 0;
    end else if (ien) begin
      foreach (ages[i]) begin
        if (ib && ages[i] >= minD) hits++;
        else if (ages[i] == maxD) fl = 1'b1;
        else nxt.push_back(ages[i] + 1);
      end
      if (ia) nxt.push_back(1);
      ages = nxt;
      mCnt = (mCnt + hits > cntMax) ? cntMax : mCnt + hits;
      fCnt = (fCnt + int'(fl) > cntMax) ? cntMax : fCnt + int'(fl);
    end
    e.match = (hits > 0);
    e.fail  = fl;
    e.busy  = (ages.size() > 0);
    e.mcnt  = 16'(mCnt);
    e.fcnt  = 16'(fCnt);
  endtask

  // Called at a negedge; drives one cycle, queues its prediction and returns at the next negedge.
  task automatic applyStimulus(input logic ia, ib, ien, iclr, irst);
    obs_t e;
    a = ia; b = ib; en = ien; clear = iclr; rst_n = irst;
    modelStep(ia, ib, ien, iclr, irst, e);
    expq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic startTest(input int s);
    obs_t dummy;
    sel = s;
    maxD = 4;
    minD = (s == 1) ? 2 : 1;
    cntMax = (s == 2) ? 3 : 65535;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dummy = expq.pop_front();
  endtask

  task automatic test_reset();
    obs_t got, exp;
    sel = 0; maxD = 4; minD = 1; cntMax = 65535;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp || got !== '0) begin
        failures++;
        $display("[TB] FAIL reset c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d required all zero",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt);
      end
    end
  endtask

  task automatic test_single_match();
    obs_t got, exp;
    startTest(0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c == 0, c == 1, 1'b1, 1'b0, 1'b1);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL single_match c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c == 1) begin
        checks++;
        if (got.match !== 1'b1 || got.mcnt !== 16'd1 || got.busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL single_match_pulse got m=%b mc=%0d busy=%b required m=1 mc=1 busy=0", got.match, got.mcnt, got.busy);
        end
      end
    end
  endtask

  task automatic test_expiry();
    obs_t got, exp;
    startTest(0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b1, 1'b0, 1'b1);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL expiry c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c == 4) begin
        checks++;
        if (got.fail !== 1'b1 || got.fcnt !== 16'd1 || got.match !== 1'b0) begin
          failures++;
          $display("[TB] FAIL expiry_pulse got f=%b fc=%0d m=%b required f=1 fc=1 m=0", got.fail, got.fcnt, got.match);
        end
      end
    end
  endtask

  task automatic test_min_delay();
    obs_t got, exp;
    startTest(1);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c <= 1, c == 2, 1'b1, 1'b0, 1'b1);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL min_delay c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c == 2 || c == 5) begin
        checks++;
        if ((c == 2 && (got.match !== 1'b1 || got.mcnt !== 16'd1)) || (c == 5 && got.fail !== 1'b1)) begin
          failures++;
          $display("[TB] FAIL min_delay_pulse c=%0d got m=%b mc=%0d f=%b", c, got.match, got.mcnt, got.fail);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    startTest(0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(c <= 2, c == 3, 1'b1, 1'b0, 1'b1);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c == 3) begin
        checks++;
        if (got.match !== 1'b1 || got.mcnt !== 16'd3 || got.busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL back_to_back_cnt got m=%b mc=%0d busy=%b required m=1 mc=3 busy=0", got.match, got.mcnt, got.busy);
        end
      end
    end
  endtask

  task automatic test_same_cycle_and_enable();
    obs_t got, exp;
    startTest(0);
    // a&b together at c=0 must not match; en low for c=1..3 freezes the attempt and ignores b at c=2.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c == 0, c == 0 || c == 2 || c == 4, !(c >= 1 && c <= 3), 1'b0, 1'b1);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL same_cycle_enable c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c == 0 || c == 2 || c == 4) begin
        checks++;
        if (got.match !== (c == 4) || got.busy !== (c != 4)) begin
          failures++;
          $display("[TB] FAIL same_cycle_enable_pulse c=%0d got m=%b busy=%b", c, got.match, got.busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    startTest(0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c == 0, c == 4, 1'b1, 1'b0, !(c == 2 || c == 3));
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reset_mid c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c >= 2) begin
        checks++;
        if (got !== '0) begin
          failures++;
          $display("[TB] FAIL reset_mid_quiet c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d required all zero",
                   c, got.match, got.fail, got.busy, got.mcnt, got.fcnt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    obs_t got, exp;
    startTest(2);
    for (int c = 0; c < 18; c++) begin
      applyStimulus(c < 16 && c % 2 == 0, c < 16 && c % 2 == 1, 1'b1, c == 16, 1'b1);
      exp = expq.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL saturation c=%0d got m=%b f=%b busy=%b mc=%0d fc=%0d exp m=%b f=%b busy=%b mc=%0d fc=%0d",
                 c, got.match, got.fail, got.busy, got.mcnt, got.fcnt, exp.match, exp.fail, exp.busy, exp.mcnt, exp.fcnt);
      end
      if (c == 15 || c == 16) begin
        checks++;
        if (got.mcnt !== ((c == 15) ? 16'd3 : 16'd0)) begin
          failures++;
          $display("[TB] FAIL saturation_cnt c=%0d got mc=%0d required %0d", c, got.mcnt, (c == 15) ? 3 : 0);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_match();
    test_expiry();
    test_min_delay();
    test_back_to_back();
    test_same_cycle_and_enable();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_delay_range_monitor.md
Name: seq_delay_range_monitor

Overview:
- Generalises the single-cycle "a then b" recogniser to the range sequence "a ##[MIN_DELAY:MAX_DELAY] b".
- Tracks overlapping attempts: every cycle with a sampled high starts a new one.
- Produces registered match/fail pulses that feed the cover/assert layer directly downstream.
- Keeps saturating match/fail counters for end-of-test reporting.

Parameters:
MIN_DELAY, 1, earliest cycle after a at which b completes the sequence; legal range 1..MAX_DELAY.
MAX_DELAY, 4, latest cycle after a at which b completes the sequence; legal range MIN_DELAY..31.
CNT_W, 16, width of match_cnt and fail_cnt.

Ports:
clk  input  1  sampling clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  sample enable; when low, all state holds.
clear  input  1  synchronous clear of attempts, pulses and counters; wins over en.
a  input  1  sequence start condition.
b  input  1  sequence completion condition.
match  output  1  one-cycle pulse: at least one attempt completed at the previous sampling edge.
fail  output  1  one-cycle pulse: the oldest attempt expired without b at the previous sampling edge.
busy  output  1  high while any attempt is pending, i.e. OR of the pending vector.
match_cnt  output  CNT_W  number of attempts completed; saturates at all-ones.
fail_cnt  output  CNT_W  number of attempts expired; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): pending vector, match, fail, match_cnt and fail_cnt are all 0.
- State: pending vector p[1..MAX_DELAY]. p[k]=1 means an attempt started k sampling edges ago is still alive.
- Evaluation at each posedge with en=1 and clear=0:
  - hit[k] = p[k] && b && (k >= MIN_DELAY).
  - match <= |hit.
  - fail <= p[MAX_DELAY] && !hit[MAX_DELAY].
  - p[1] <= a.
  - p[k+1] <= p[k] && !hit[k], for k in 1..MAX_DELAY-1.
  - The oldest slot drops out after evaluation.
- Latency: match/fail are registered and assert the cycle after the edge that sampled b or the expiry.
- One b retires every eligible pending attempt in that cycle. match is a single pulse; match_cnt increments by popcount(hit).
- fail_cnt increments by 1 on each fail. Counters saturate and never wrap.
- Delay 0 is never legal: a and b high in the same cycle start an attempt but do not complete it.
- Slots p[k] with k < MIN_DELAY ignore b and keep ageing.
- The same cycle may produce match (a younger attempt hits) and fail (the oldest expires); both pulses assert.
- en=0: p and counters hold. match and fail are 0 on the following cycle.
- clear=1 at posedge: p, match, fail and both counters become 0. No fail is reported for discarded attempts.
- Reset mid-operation: all pending attempts are silently discarded; no match/fail pulse follows deassertion.
- Elaboration check: MIN_DELAY < 1, MAX_DELAY < MIN_DELAY or MAX_DELAY > 31 is a fatal error.

Decomposition:
- Package seq_mon_pkg holds MAX_DELAY_LIMIT=31 and the popcount function used for hit.
- Sub-module sat_counter: parameter W; inputs clk, rst_n, clr, inc (value 0..MAX_DELAY); output cnt; saturates at 2^W-1.
- Two instances, one for match_cnt and one for fail_cnt.

Test Plan:
- Defaults, a=1 at cycle 0, b=1 at cycle 1 -> match=1 at cycle 2; match_cnt=1; fail never asserts; busy low from cycle 2.
- Defaults, a=1 at cycle 0 only, b held 0 -> fail=1 at cycle 5 (expiry evaluated at edge 4); fail_cnt=1; match stays 0.
- MIN_DELAY=2, a=1 at cycles 0 and 1, b=1 at cycle 2 only -> attempt 0 hits, attempt 1 is too young; match=1 at cycle 3, match_cnt=1; attempt 1 fails at cycle 6.
- Defaults, a=1 at cycles 0,1,2, b=1 at cycle 3 -> single match pulse at cycle 4; match_cnt=3; busy=0 at cycle 4.
- a=1 at cycle 0, rst_n low for cycles 2-3, b=1 at cycle 4 -> no match, no fail; counters 0; busy=0 from reset onward.
- CNT_W=2, eight separate a/b pairs at delay 1 -> match_cnt reads 3 after the third match and stays 3; then clear=1 -> match_cnt=0 the next cycle.
